// File: rtl/arbiter_pkg.sv
// Shared instruction field positions and the {dst, src} address-pair type
// used by the dispatch arbiter and its per-lane shadow queues.
package arbiter_pkg;

    localparam int unsigned FORCE_BIT = 28;
    localparam int unsigned LANE_HI   = 27;
    localparam int unsigned LANE_LO   = 26;
    localparam int unsigned DST_HI    = 17;
    localparam int unsigned DST_LO    = 9;
    localparam int unsigned SRC_HI    = 8;
    localparam int unsigned SRC_LO    = 0;

    typedef struct packed {
        logic [DST_HI-DST_LO:0] dst;
        logic [SRC_HI-SRC_LO:0] src;
    } addr_pair_t;

endpackage

// File: rtl/dep_shadow_queue.sv
// Per-lane circular queue of in-flight {dst, src} pairs, with occupancy count and a
// combinational dependency match against a presented pair.
module dep_shadow_queue
    import arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  addr_pair_t       wr_pair,
    input  addr_pair_t       cmp_pair,
    output logic             match,
    output logic [CNT_W-1:0] count
);

    addr_pair_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] offset;
    logic             pop_eff;

    // A pop on an empty queue is dropped so the count never underflows.
    assign pop_eff = pop && (count_q != '0);
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_pair;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop_eff) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_eff && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        match  = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) &&
                ((cmp_pair.dst == mem_q[i].dst) || (cmp_pair.src == mem_q[i].src) ||
                 (cmp_pair.dst == mem_q[i].src) || (cmp_pair.src == mem_q[i].dst))) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispatch_arbiter.sv
// Dispatches one instruction per cycle into NUM_LANES downstream FIFOs, keeping
// instructions that share addresses with in-flight work in the same lane.
module dispatch_arbiter
    import arbiter_pkg::*;
#(
    parameter  int unsigned NUM_LANES = 2,
    parameter  int unsigned INSTR_W   = 32,
    parameter  int unsigned ADDR_W    = 9,
    parameter  int unsigned DEPTH     = 8,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic [NUM_LANES-1:0]       lane_push,
    output logic [INSTR_W-1:0]         lane_data,
    input  logic [NUM_LANES-1:0]       lane_full,
    input  logic [NUM_LANES-1:0]       lane_pop,
    output logic [NUM_LANES*CNT_W-1:0] lane_count,
    output logic                       stall_conflict
);

    localparam int unsigned IDX_W = $clog2(NUM_LANES);

    addr_pair_t           new_pair;
    logic [NUM_LANES-1:0] match;
    logic [NUM_LANES-1:0] push;
    logic [CNT_W-1:0]     cnt [NUM_LANES];
    logic [CNT_W-1:0]     min_cnt;
    logic [IDX_W-1:0]     forced_idx;
    logic [IDX_W-1:0]     match_idx;
    logic [IDX_W-1:0]     min_idx;
    logic [IDX_W-1:0]     target;
    logic [2:0]           n_match;
    logic                 force_lane;
    logic                 has_target;
    logic                 multi_match;
    logic                 accept;

    assign new_pair.dst = in_instr[DST_LO +: ADDR_W];
    assign new_pair.src = in_instr[SRC_LO +: ADDR_W];
    assign force_lane   = in_instr[FORCE_BIT];
    assign forced_idx   = IDX_W'({1'b0, in_instr[LANE_HI:LANE_LO]} % 3'(NUM_LANES));

    always_comb begin
        n_match   = '0;
        match_idx = '0;
        min_idx   = '0;
        min_cnt   = cnt[0];
        for (int k = 0; k < NUM_LANES; k++) begin
            if (match[k]) begin
                n_match   = n_match + 3'd1;
                match_idx = IDX_W'(k);
            end
            if (cnt[k] < min_cnt) begin
                min_cnt = cnt[k];
                min_idx = IDX_W'(k);
            end
        end

        has_target  = 1'b1;
        multi_match = 1'b0;
        target      = min_idx;
        if (force_lane) begin
            target = forced_idx;
        end else if (n_match == 3'd1) begin
            target = match_idx;
        end else if (n_match > 3'd1) begin
            has_target  = 1'b0;
            multi_match = 1'b1;
        end
    end

    // A blocked target stalls the input rather than redirecting, to keep ordering.
    assign in_ready = !reset && has_target && !lane_full[target] &&
                      (cnt[target] < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign push[k] = accept && (target == IDX_W'(k));

        dep_shadow_queue #(
            .DEPTH (DEPTH)
        ) u_queue (
            .clk      (clk),
            .reset    (reset),
            .push     (push[k]),
            .pop      (lane_pop[k]),
            .wr_pair  (new_pair),
            .cmp_pair (new_pair),
            .match    (match[k]),
            .count    (cnt[k])
        );

        assign lane_count[k*CNT_W +: CNT_W] = cnt[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_push      <= '0;
            lane_data      <= '0;
            stall_conflict <= 1'b0;
        end else begin
            lane_push      <= push;
            stall_conflict <= in_valid && multi_match;
            if (accept) begin
                lane_data <= in_instr;
            end
        end
    end

endmodule
